// File: rtl/accu_bank_alu.sv
// Bank of num_acc accumulators with a small ALU and a shift-and-add multiplier.
// Define ACCU_BANK_MUL_EN to build the multi-cycle MUL datapath and MUL_BUSY state.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OP_CODE_WIDTH
`define OP_CODE_WIDTH 4
`endif

module accu_bank_alu #(
    parameter int unsigned data_width    = `DATA_WIDTH,
    parameter int unsigned op_code_width = `OP_CODE_WIDTH,
    parameter int unsigned num_acc       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [op_code_width-1:0]   opcode,
    input  logic [$clog2(num_acc)-1:0] acc_sel,
    input  logic [data_width-1:0]      data_in,
    output logic [data_width-1:0]      data_out,
    output logic                       cy,
    output logic                       zero,
    output logic                       done
);
    localparam int unsigned W     = data_width;
    localparam int unsigned OP_W  = op_code_width;
    localparam int unsigned SEL_W = $clog2(num_acc);

    localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADC  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(9);

    logic [W-1:0] acc_q [num_acc];
    logic [W-1:0] acc_d [num_acc];
    logic [num_acc-1:0] cy_q, cy_d;
    logic done_q, done_d;
    logic accept;

    logic [W-1:0] opa, alu_acc;
    logic         alu_cy;

    // Single-cycle ALU on the selected accumulator; NOP and unknown opcodes pass through.
    always_comb begin
        opa     = acc_q[acc_sel];
        alu_acc = opa;
        alu_cy  = cy_q[acc_sel];
        case (opcode)
            OP_LOAD: begin alu_acc = data_in; alu_cy = 1'b0; end
            OP_ADD:  {alu_cy, alu_acc} = {1'b0, opa} + {1'b0, data_in};
            OP_ADC:  {alu_cy, alu_acc} = {1'b0, opa} + {1'b0, data_in} + (W+1)'(cy_q[acc_sel]);
            OP_SUB:  {alu_cy, alu_acc} = {1'b0, opa} - {1'b0, data_in};
            OP_AND:  alu_acc = opa & data_in;
            OP_OR:   alu_acc = opa | data_in;
            OP_XOR:  alu_acc = opa ^ data_in;
            OP_NOT:  alu_acc = ~opa;
            OP_SHL:  begin alu_cy = opa[W-1]; alu_acc = {opa[W-2:0], 1'b0}; end
            OP_SHR:  begin alu_cy = opa[0];   alu_acc = {1'b0, opa[W-1:1]}; end
            default: ;
        endcase
    end

`ifdef ACCU_BANK_MUL_EN
    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(10);

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   mcand_q, mcand_d, prod_q, prod_d, prod_sum;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             is_mul, mul_last;

    assign accept   = in_valid && in_ready;
    assign is_mul   = (opcode == OP_MUL);
    assign mul_last = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(W-1));
    assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_last)         state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath: single-cycle writes in IDLE, one multiplier bit per MUL_BUSY cycle.
    always_comb begin
        acc_d    = acc_q;
        cy_d     = cy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        tgt_d    = tgt_q;
        if (state_q == IDLE) begin
            if (accept && is_mul) begin
                mcand_d  = {W'(0), acc_q[acc_sel]};
                mplier_d = data_in;
                prod_d   = '0;
                cnt_d    = '0;
                tgt_d    = acc_sel;
            end else if (accept) begin
                acc_d[acc_sel] = alu_acc;
                cy_d[acc_sel]  = alu_cy;
                done_d         = 1'b1;
            end
        end else begin
            prod_d   = prod_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_last) begin
                acc_d[tgt_q] = prod_sum[W-1:0];
                cy_d[tgt_q]  = |prod_sum[2*W-1:W];
                done_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            tgt_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            tgt_q    <= tgt_d;
        end
    end
`else
    assign in_ready = 1'b1;
    assign accept   = in_valid;

    always_comb begin
        acc_d  = acc_q;
        cy_d   = cy_q;
        done_d = 1'b0;
        if (accept) begin
            acc_d[acc_sel] = alu_acc;
            cy_d[acc_sel]  = alu_cy;
            done_d         = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(num_acc); i++) acc_q[i] <= '0;
            cy_q   <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cy_q   <= cy_d;
            done_q <= done_d;
        end
    end

    assign data_out = acc_q[acc_sel];
    assign cy       = cy_q[acc_sel];
    assign zero     = (acc_q[acc_sel] == '0);
    assign done     = done_q;

endmodule

// File: tb/tb_accu_bank_alu.sv
// Self-checking bench for accu_bank_alu (8-bit, 4 accumulators) with an arithmetic reference model.
// Exercises the MUL path when ACCU_BANK_MUL_EN is defined, otherwise checks opcode 10 as NOP.
module tb_accu_bank_alu;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [1:0] acc_sel;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       cy;
    logic       zero;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;
    int m_acc [4];
    int m_cy  [4];
`ifdef ACCU_BANK_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    accu_bank_alu #(.data_width(8), .op_code_width(4), .num_acc(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .acc_sel(acc_sel), .data_in(data_in),
        .data_out(data_out), .cy(cy), .zero(zero), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_cy[i] = 0; end
    endtask

    // Reference behaviour from the opcode table using plain integer arithmetic.
    task automatic model_apply(input int op, input int s, input int b);
        int a, c, t;
        a = m_acc[s];
        c = m_cy[s];
        case (op)
            0:  begin m_acc[s] = b; m_cy[s] = 0; end
            1:  begin t = a + b;     m_acc[s] = t % 256; m_cy[s] = (t > 255); end
            2:  begin t = a + b + c; m_acc[s] = t % 256; m_cy[s] = (t > 255); end
            3:  begin m_acc[s] = (a - b + 256) % 256; m_cy[s] = (a < b); end
            4:  m_acc[s] = a & b;
            5:  m_acc[s] = a | b;
            6:  m_acc[s] = a ^ b;
            7:  m_acc[s] = 255 - a;
            8:  begin m_acc[s] = (a * 2) % 256; m_cy[s] = a / 128; end
            9:  begin m_acc[s] = a / 2; m_cy[s] = a % 2; end
            10: if (MUL_EN) begin t = a * b; m_acc[s] = t % 256; m_cy[s] = (t > 255); end
            default: ;
        endcase
    endtask

    task automatic issue(input int op, input int s, input int b);
        @(negedge clk);
        chk("ready_before_req", in_ready, 1);
        in_valid = 1'b1; opcode = 4'(op); acc_sel = 2'(s); data_in = 8'(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_apply(op, s, b);
        chk($sformatf("done_op%0d", op), done, 1);
        chk($sformatf("acc_op%0d_sel%0d", op, s), data_out, m_acc[s]);
        chk($sformatf("cy_op%0d_sel%0d", op, s), cy, m_cy[s]);
        chk($sformatf("zero_op%0d_sel%0d", op, s), zero, (m_acc[s] == 0));
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            acc_sel = 2'(i);
            #1;
            chk($sformatf("%s_acc%0d", tag, i), data_out, m_acc[i]);
            chk($sformatf("%s_cy%0d", tag, i), cy, m_cy[i]);
        end
    endtask

`ifdef ACCU_BANK_MUL_EN
    task automatic mul(input int s, input int b);
        int lows, dones;
        lows = 0; dones = 0;
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd10; acc_sel = 2'(s); data_in = 8'(b);
        @(posedge clk); #1;
        opcode = 4'd0; data_in = 8'hAA;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!in_ready) lows++;
            if (done) dones++;
            in_valid = !in_ready;
        end
        in_valid = 1'b0;
        model_apply(10, s, b);
        #1;
        chk("mul_ready_low_cycles", lows, 8);
        chk("mul_done_pulses", dones, 1);
        chk("mul_acc", data_out, m_acc[s]);
        chk("mul_cy", cy, m_cy[s]);
    endtask
`endif

    initial begin
        int done_seen;
        rst = 1'b1; in_valid = 1'b0; opcode = '0; acc_sel = '0; data_in = '0;
        model_reset();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            acc_sel = 2'(i); #1;
            chk($sformatf("rst_acc%0d", i), data_out, 0);
            chk($sformatf("rst_cy%0d", i), cy, 0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Add with carry chain
        issue(0, 0, 8'hF0);
        issue(1, 0, 8'h20);
        chk("add_acc0_10", data_out, 8'h10);
        chk("add_cy_1", cy, 1);
        issue(2, 0, 8'h00);
        chk("adc_acc0_11", data_out, 8'h11);
        chk("adc_cy_0", cy, 0);

        // Subtract with borrow and zero flag
        issue(0, 1, 8'h05);
        issue(3, 1, 8'h06);
        chk("sub_acc1_ff", data_out, 8'hFF);
        chk("sub_borrow", cy, 1);
        chk("sub_zero_0", zero, 0);
        issue(3, 1, 8'hFF);
        chk("sub_acc1_00", data_out, 8'h00);
        chk("sub_zero_1", zero, 1);
        chk("sub_cy_0", cy, 0);

        // Shifts, others untouched
        issue(0, 2, 8'h81);
        issue(8, 2, 0);
        chk("shl_02", data_out, 8'h02);
        chk("shl_cy", cy, 1);
        issue(9, 2, 0);
        chk("shr_01", data_out, 8'h01);
        chk("shr_cy", cy, 0);
        check_all("after_shift");

        // Logic ops keep carry, NOP keeps everything but pulses done
        issue(1, 3, 8'hFF); issue(1, 3, 8'h01);
        issue(4, 3, 8'h0F); issue(5, 3, 8'hA0); issue(6, 3, 8'h33); issue(7, 3, 0);
        issue(12, 3, 8'h77); issue(15, 0, 8'h12);
`ifndef ACCU_BANK_MUL_EN
        issue(10, 1, 8'h55);
`endif
        check_all("after_logic");

`ifdef ACCU_BANK_MUL_EN
        issue(0, 3, 8'h10);
        mul(3, 8'h20);
        chk("mul_10x20_acc", data_out, 8'h00);
        chk("mul_10x20_cy", cy, 1);
        issue(0, 3, 8'h05);
        mul(3, 8'h03);
        chk("mul_05x03_acc", data_out, 8'h0F);
        chk("mul_05x03_cy", cy, 0);
        check_all("after_mul");

        // Reset in the middle of a multiply
        issue(0, 3, 8'h10);
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd10; acc_sel = 2'd3; data_in = 8'h20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
`endif
        // Asynchronous reset mid-sequence
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        acc_sel = 2'd3; #1;
        chk("midrst_acc3", data_out, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_late_done", done_seen, 0);
        check_all("after_midrst");

        // First request accepted on the first edge after reset release
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; opcode = 4'd0; acc_sel = 2'd1; data_in = 8'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_reset();
        model_apply(0, 1, 8'h3C);
        chk("first_req_acc", data_out, 8'h3C);
        chk("first_req_done", done, 1);

        // Randomised back-to-back single-cycle traffic
        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (MUL_EN && op == 10) op = 11;
            issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            if (n % 30 == 29) check_all("rand");
        end
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/accu_bank_alu.md
ACCU_BANK_ALU -- requirements
Module: accu_bank_alu

Interface
REQ-001 SHALL have parameter data_width, default `data_width, operand and accumulator width (min 4).
REQ-002 SHALL have parameter op_code_width, default `op_code_width, opcode width (min 4).
REQ-003 SHALL have parameter num_acc, default 4, number of accumulators (power of two, min 2).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-008 SHALL have port opcode  input  op_code_width  operation select.
REQ-009 SHALL have port acc_sel  input  $clog2(num_acc)  target accumulator of request; also selects the read view.
REQ-010 SHALL have port data_in  input  data_width  operand B.
REQ-011 SHALL have port data_out  output  data_width  accumulator acc_sel, combinational read.
REQ-012 SHALL have port cy  output  1  carry flag of accumulator acc_sel.
REQ-013 SHALL have port zero  output  1  high when data_out == 0.
REQ-014 SHALL have port done  output  1  one-cycle pulse, a result was written on the preceding edge.

Function
REQ-015 Request SHALL be accepted on a rising edge where in_valid && in_ready; opcode, acc_sel and data_in are sampled only then.
REQ-016 Opcodes SHALL be: 0 LOAD (acc=B, cy=0), 1 ADD (acc+B, cy=carry out), 2 ADC (acc+B+cy), 3 SUB (acc-B, cy=borrow), 4 AND, 5 OR, 6 XOR, 7 NOT (~acc), 8 SHL (cy=old msb, lsb=0), 9 SHR (cy=old lsb, msb=0), 10 MUL, 11-max NOP.
REQ-017 AND/OR/XOR/NOT SHALL leave cy unchanged; NOP SHALL change no accumulator or carry but still pulse done.
REQ-018 Arithmetic SHALL be unsigned modulo 2^data_width, result truncated to data_width, carry from bit data_width.
REQ-019 Single-cycle ops SHALL write the target accumulator and carry on the accepting edge; done high the following cycle; in_ready stays high.
REQ-020 FSM SHALL have states IDLE and MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE after the final iteration.
REQ-021 MUL SHALL be shift-and-add, one multiplier bit per cycle, data_width cycles in MUL_BUSY; product low half written to target accumulator on the last MUL_BUSY edge; cy=1 iff product high half nonzero.
REQ-022 in_ready SHALL be low throughout MUL_BUSY; in_valid during MUL_BUSY is ignored, not queued.
REQ-023 MUL operands SHALL be the target accumulator value and data_in captured at acceptance; target index is latched.
REQ-024 Back-to-back single-cycle requests SHALL execute every cycle; ADC after ADD SHALL see the carry written by the ADD.
REQ-025 Accumulators not targeted SHALL hold value and carry.
REQ-026 data_out/cy/zero SHALL track acc_sel combinationally, independent of FSM state.

Reset
REQ-027 On rst high, asynchronously: all accumulators 0, all carries 0, FSM IDLE, done 0, in_ready 1.
REQ-028 rst during MUL_BUSY SHALL abort the multiply; no partial result is written.
REQ-029 First request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro ACCU_BANK_MUL_EN SHALL compile in the MUL datapath and MUL_BUSY state.
REQ-031 Without ACCU_BANK_MUL_EN, opcode 10 SHALL behave as NOP, in_ready SHALL be constant 1, no MUL_BUSY state exists.

Verification (data_width=8, num_acc=4)
REQ-032 LOAD acc0=0xF0, ADD 0x20 to acc0 -> acc0=0x10, cy=1; ADC 0x00 -> acc0=0x11, cy=0.
REQ-033 LOAD acc1=0x05, SUB 0x06 -> acc1=0xFF, cy=1, zero=0; SUB 0xFF -> acc1=0x00, zero=1, cy=0.
REQ-034 LOAD acc2=0x81, SHL -> 0x02, cy=1; SHR -> 0x01, cy=0; acc0/acc1 unchanged.
REQ-035 (MUL_EN) LOAD acc3=0x10, MUL 0x20 -> in_ready low 8 cycles, acc3=0x00, cy=1, done pulses once; MUL 0x03 on acc=0x05 -> 0x0F, cy=0.
REQ-036 Assert rst 3 cycles into a MUL on acc3 holding 0x10 -> acc3=0x00, in_ready=1, done=0, no later write.
